// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, state encoding and datapath select codes for control_multi
package ctrl_pkg;

    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - counts memory wait cycles; done when count reaches MEM_WAIT
module mem_wait_counter #(
    parameter int CNT_W    = 4,
    parameter int MEM_WAIT = 0
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(MEM_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == WAIT_V);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/control_multi.sv
// rtl/control_multi.sv - multi-cycle MIPS control FSM with memory wait states
// Build option: CTRL_MC_ILLEGAL_TRAP_EN makes unknown opcodes lock in TRAP until reset.
module control_multi
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        PCWriteCondNe,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state
);

    state_e     state_q, state_d;
    logic       bne_q, bne_d;
    logic       mem_state;
    logic       wait_done;
    logic [5:0] op;

    assign op        = instr[31:26];
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign state     = rst ? 4'd0 : state_q;

    mem_wait_counter #(
        .CNT_W    (CNT_W),
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk    (clk),
        .clear  (rst || !mem_state || wait_done),
        .enable (mem_state),
        .done   (wait_done)
    );

    always_comb begin
        state_d       = state_q;
        bne_d         = bne_q;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_B;
        ALUOp         = ALUOP_ADD;
        PCSource      = PCSRC_ALU;
        retire        = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (wait_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                // branch flavour is latched so BRANCH outputs depend on state only
                bne_d   = (op == OP_BNE);
                if (instr == 32'd0) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_R:           state_d = S_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        OP_ADDIU:       state_d = S_ADDI_EX;
                        default: begin
`ifdef CTRL_MC_ILLEGAL_TRAP_EN
                            state_d = S_TRAP;
`else
                            illegal = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
`endif
                        end
                    endcase
                end
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (wait_done) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (wait_done) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALUOP_SUB;
                PCSource      = PCSRC_ALUOUT;
                PCWriteCond   = !bne_q;
                PCWriteCondNe = bne_q;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            state_d       = S_FETCH;
            bne_d         = 1'b0;
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            PCWriteCondNe = 1'b0;
            IorD          = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            MemtoReg      = 1'b0;
            RegDst        = 1'b0;
            RegWrite      = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = SRCB_B;
            ALUOp         = ALUOP_ADD;
            PCSource      = PCSRC_ALU;
            retire        = 1'b0;
            illegal       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        bne_q   <= bne_d;
    end

endmodule
